lcd_ydriver_sequencer: RTL and testbench

Generates the row-driver control pins S (frame start), CPL (line latch clock) and FR (polarity) from the system dot clock, sequencing the Y-driver's shift register through one frame of active lines plus vertical blank. Sits between the video timing core and the LCD panel pins. It also exports dot/line counters and a data-window strobe so the column-data path stays aligned with row scanning.

---
 rtl/lcd_seq_pkg.sv | 22 ++
 rtl/lcd_dot_line_counter.sv | 64 ++++++
 rtl/lcd_ydriver_sequencer.sv | 105 ++++++++++
 tb/tb_lcd_ydriver_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/lcd_seq_pkg.sv
// Shared types and default timing for the LCD Y-driver sequencer.
// Counter widths match the LX/LY pin widths.
package lcd_seq_pkg;

  typedef enum logic [1:0] {
    OFF,
    SCAN,
    VBLANK
  } seq_state_e;

  localparam int H_TOTAL_DEF      = 456;
  localparam int V_TOTAL_DEF      = 154;
  localparam int V_ACTIVE_DEF     = 144;
  localparam int H_DATA_START_DEF = 80;
  localparam int H_DATA_LEN_DEF   = 160;
  localparam int CPL_LEN_DEF      = 4;
  localparam int FR_LINE_INV_DEF  = 0;

  localparam int LX_W = 9;
  localparam int LY_W = 8;

endpackage

// File: rtl/lcd_dot_line_counter.sv
// Dot/line counter with wrap, next-value taps and a registered
// last-dot-of-frame pulse.
module lcd_dot_line_counter
  import lcd_seq_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  output logic [LX_W-1:0] lx_o,
  output logic [LY_W-1:0] ly_o,
  output logic [LX_W-1:0] lx_d_o,
  output logic [LY_W-1:0] ly_d_o,
  output logic            line_last_o,
  output logic            frame_last_o,
  output logic            frame_end_o
);

  localparam logic [LX_W-1:0] LX_LAST = LX_W'(H_TOTAL - 1);
  localparam logic [LY_W-1:0] LY_LAST = LY_W'(V_TOTAL - 1);

  logic [LX_W-1:0] lx_q, lx_d;
  logic [LY_W-1:0] ly_q, ly_d;
  logic            fe_q, fe_d;
  logic            line_last;

  assign line_last = (lx_q == LX_LAST);

  always_comb begin
    lx_d = '0;
    ly_d = '0;
    if (run_i) begin
      lx_d = line_last ? '0 : lx_q + 1'b1;
      ly_d = ly_q;
      if (line_last) begin
        ly_d = (ly_q == LY_LAST) ? '0 : ly_q + 1'b1;
      end
    end
    fe_d = run_i && (lx_d == LX_LAST) && (ly_d == LY_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lx_q <= '0;
      ly_q <= '0;
      fe_q <= 1'b0;
    end else begin
      lx_q <= lx_d;
      ly_q <= ly_d;
      fe_q <= fe_d;
    end
  end

  assign lx_o         = lx_q;
  assign ly_o         = ly_q;
  assign lx_d_o       = lx_d;
  assign ly_d_o       = ly_d;
  assign line_last_o  = line_last;
  assign frame_last_o = line_last && (ly_q == LY_LAST);
  assign frame_end_o  = fe_q;

endmodule

// File: rtl/lcd_ydriver_sequencer.sv
// Y-driver sequencer: OFF/SCAN/VBLANK FSM and registered S/CPL/FR/DATA_EN
// decode, aligned to the LX/LY values they accompany.
module lcd_ydriver_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int H_DATA_START = H_DATA_START_DEF,
  parameter int H_DATA_LEN   = H_DATA_LEN_DEF,
  parameter int CPL_LEN      = CPL_LEN_DEF,
  parameter int FR_LINE_INV  = FR_LINE_INV_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EN,
  output logic            S,
  output logic            CPL,
  output logic            FR,
  output logic            DATA_EN,
  output logic [LX_W-1:0] LX,
  output logic [LY_W-1:0] LY,
  output logic            FRAME_END
);

  localparam logic [LX_W-1:0] LX_CPL = LX_W'(H_TOTAL - CPL_LEN);
  localparam logic [LX_W-1:0] LX_DLO = LX_W'(H_DATA_START);
  localparam logic [LX_W-1:0] LX_DHI = LX_W'(H_DATA_START + H_DATA_LEN);
  localparam logic [LY_W-1:0] LY_VA  = LY_W'(V_ACTIVE);

  seq_state_e      state_q, state_d;
  logic [LX_W-1:0] lx_d;
  logic [LY_W-1:0] ly_d;
  logic            line_last, frame_last;
  logic            run;
  logic            s_q, s_d;
  logic            cpl_q, cpl_d;
  logic            fr_q, fr_d;
  logic            den_q, den_d;
  logic            scan_d;

  assign run = EN && (state_q != OFF);

  lcd_dot_line_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_cnt (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .run_i        (run),
    .lx_o         (LX),
    .ly_o         (LY),
    .lx_d_o       (lx_d),
    .ly_d_o       (ly_d),
    .line_last_o  (line_last),
    .frame_last_o (frame_last),
    .frame_end_o  (FRAME_END)
  );

  always_comb begin
    state_d = OFF;
    if (EN) begin
      unique case (state_q)
        OFF:     state_d = SCAN;
        default: state_d = (ly_d < LY_VA) ? SCAN : VBLANK;
      endcase
    end
  end

  // Decode from next counter values so outputs land with their LX/LY.
  always_comb begin
    scan_d = (state_d == SCAN);
    s_d    = scan_d && (ly_d == '0);
    cpl_d  = scan_d && (lx_d >= LX_CPL);
    den_d  = scan_d && (lx_d >= LX_DLO) && (lx_d < LX_DHI);
    fr_d   = fr_q;
    if (state_d == OFF || state_q == OFF) begin
      fr_d = 1'b0;
    end else if (frame_last || (FR_LINE_INV != 0 && line_last)) begin
      fr_d = ~fr_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= OFF;
      s_q     <= 1'b0;
      cpl_q   <= 1'b0;
      fr_q    <= 1'b0;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cpl_q   <= cpl_d;
      fr_q    <= fr_d;
      den_q   <= den_d;
    end
  end

  assign S       = s_q;
  assign CPL     = cpl_q;
  assign FR      = fr_q;
  assign DATA_EN = den_q;

endmodule

// File: tb/tb_lcd_ydriver_sequencer.sv
// Directed + randomized bench for lcd_ydriver_sequencer against a
// time-since-enable reference model.
module tb_lcd_ydriver_sequencer;

  localparam int H  = 8;
  localparam int V  = 5;
  localparam int VA = 3;
  localparam int CL = 2;
  localparam int DS = 1;
  localparam int DL = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN = 1'b0;
  logic       s0, cpl0, fr0, den0, fe0;
  logic [8:0] lx0;
  logic [7:0] ly0;
  logic       s1, cpl1, fr1, den1, fe1;
  logic [8:0] lx1;
  logic [7:0] ly1;

  int vectors = 0;
  int miscompares = 0;

  bit on = 0;
  int t = 0;

  lcd_ydriver_sequencer #(
    .H_TOTAL(H), .V_TOTAL(V), .V_ACTIVE(VA), .H_DATA_START(DS),
    .H_DATA_LEN(DL), .CPL_LEN(CL), .FR_LINE_INV(0)
  ) dut0 (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .S(s0), .CPL(cpl0), .FR(fr0), .DATA_EN(den0),
    .LX(lx0), .LY(ly0), .FRAME_END(fe0)
  );

  lcd_ydriver_sequencer #(
    .H_TOTAL(H), .V_TOTAL(V), .V_ACTIVE(VA), .H_DATA_START(DS),
    .H_DATA_LEN(DL), .CPL_LEN(CL), .FR_LINE_INV(1)
  ) dut1 (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .S(s1), .CPL(cpl1), .FR(fr1), .DATA_EN(den1),
    .LX(lx1), .LY(ly1), .FRAME_END(fe1)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_lx();
    return on ? t % H : 0;
  endfunction

  function automatic int m_ly();
    return on ? (t / H) % V : 0;
  endfunction

  task automatic check_all();
    int lx, ly;
    logic act;
    lx  = m_lx();
    ly  = m_ly();
    act = on && (ly < VA);
    chk("LX", 32'(lx0), lx);
    chk("LY", 32'(ly0), ly);
    chk("S", 32'(s0), 32'(on && ly == 0));
    chk("CPL", 32'(cpl0), 32'(act && lx >= H - CL));
    chk("DATA_EN", 32'(den0), 32'(act && lx >= DS && lx < DS + DL));
    chk("FRAME_END", 32'(fe0), 32'(on && lx == H - 1 && ly == V - 1));
    chk("FR", 32'(fr0), on ? (t / (H * V)) % 2 : 0);
    chk("FR_inv", 32'(fr1), on ? (t / H) % 2 : 0);
    chk("CPL_inv", 32'(cpl1), 32'(act && lx >= H - CL));
    chk("LX_inv", 32'(lx1), lx);
  endtask

  task automatic cycle(input logic r, input logic e);
    RESET = r;
    EN    = e;
    @(posedge CLK);
    if (r || !e) begin
      on = 0;
      t  = 0;
    end else if (!on) begin
      on = 1;
      t  = 0;
    end else begin
      t++;
    end
    @(negedge CLK);
    check_all();
  endtask

  // Runs one frame after a restart and checks pulse/toggle counts.
  task automatic frame_counts(input string tag);
    int  cpl_rise, s_hi, fr_tog, fe_cnt;
    logic pc, pf;
    cpl_rise = 0;
    s_hi     = int'(s0);
    fr_tog   = 0;
    fe_cnt   = 0;
    pc       = cpl0;
    pf       = fr1;
    for (int i = 0; i < H * V; i++) begin
      cycle(1'b0, 1'b1);
      if (cpl0 && !pc) cpl_rise++;
      if (i < H * V - 1 && s0) s_hi++;
      if (fr1 != pf) fr_tog++;
      if (fe0) fe_cnt++;
      pc = cpl0;
      pf = fr1;
    end
    chk({tag, "_cpl_pulses"}, cpl_rise, VA);
    chk({tag, "_s_cycles"}, s_hi, H);
    chk({tag, "_fr_inv_toggles"}, fr_tog, V);
    chk({tag, "_frame_end_cnt"}, fe_cnt, 1);
  endtask

  initial begin
    bit found;

    repeat (3) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    chk("first_S", 32'(s0), 1);
    chk("first_LX", 32'(lx0), 0);
    frame_counts("frame1");

    repeat (2 * H * V) cycle(1'b0, 1'b1);

    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (on && m_lx() == 3 && m_ly() == 1) found = 1;
      else cycle(1'b0, 1'b1);
    end
    chk("wait_lx3_ly1", 32'(found), 1);
    cycle(1'b0, 1'b0);
    chk("drop_S", 32'(s0), 0);
    chk("drop_LY", 32'(ly0), 0);
    cycle(1'b0, 1'b1);
    chk("reen_S", 32'(s0), 1);
    chk("reen_FR", 32'(fr0), 0);

    repeat (H * V + 3) cycle(1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (on && m_lx() == 6 && m_ly() < VA) found = 1;
      else cycle(1'b0, 1'b1);
    end
    chk("wait_mid_cpl", 32'(found), 1);
    chk("mid_cpl_high", 32'(cpl0), 1);
    cycle(1'b1, 1'b1);
    chk("rst_cpl", 32'(cpl0), 0);
    cycle(1'b0, 1'b1);
    chk("restart_S", 32'(s0), 1);
    frame_counts("restart");

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
